// File: rtl/down_sample_affine_loop_ctrl.sv
// down_sample_affine_loop_ctrl
//   Affine loop-nest controller for one scheduled op of the down_sample
//   pipeline. Walks a 4-level index vector in odometer order (ctrl_vars[3]
//   fastest) and raises en once per iteration. en goes to the ren/wen of the
//   op's unified-buffer ports. Issue is paced by a start delay, an initiation
//   interval and a stall input.
//
// Ports
//   clk        in   clock, all logic on posedge
//   rst        in   synchronous reset, active-high
//   flush      in   synchronous abort (same effect as rst)
//   start      in   launch request, sampled only in IDLE
//   stall      in   back-pressure, suppresses issue in the current cycle
//   en         out  issue strobe
//   ctrl_vars  out  loop indices [0]=root .. [3]=column, valid when en=1
//   busy       out  high in DELAY and RUN
//   done       out  one-cycle pulse after the final issue
//   perf_cycles, perf_stalls  out  only when DS_LOOP_CTRL_PERF_EN is defined
//
// Optional feature macro: DS_LOOP_CTRL_PERF_EN (performance counters).
//
// state | meaning
// IDLE  | waiting for start
// DELAY | counting down the start delay
// RUN   | issuing iterations, paced by II and stall
// DONE  | one-cycle done pulse, then back to IDLE

module down_sample_affine_loop_ctrl #(
  parameter int EXTENT0     = 1,
  parameter int EXTENT1     = 4,
  parameter int EXTENT2     = 32,
  parameter int EXTENT3     = 32,
  parameter int II          = 1,
  parameter int START_DELAY = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             start,
  input  logic             stall,
  output logic             en,
  output logic [3:0][15:0] ctrl_vars,
  output logic             busy,
  output logic             done
`ifdef DS_LOOP_CTRL_PERF_EN
  ,
  output logic [31:0]      perf_cycles,
  output logic [31:0]      perf_stalls
`endif
);

  localparam logic [15:0] E0_LAST    = 16'(EXTENT0 - 1);
  localparam logic [15:0] E1_LAST    = 16'(EXTENT1 - 1);
  localparam logic [15:0] E2_LAST    = 16'(EXTENT2 - 1);
  localparam logic [15:0] E3_LAST    = 16'(EXTENT3 - 1);
  localparam logic [7:0]  II_LAST    = 8'(II - 1);
  localparam logic [15:0] DELAY_LOAD = (START_DELAY > 0) ? 16'(START_DELAY - 1) : 16'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       ii_cnt;
  logic [15:0]      delay_cnt;
  logic [3:0][15:0] idx_inc;
  logic             wrap3;
  logic             wrap2;
  logic             wrap1;
  logic             last_iter;
  logic             issue;
  logic             accept;

  assign accept = (state == S_IDLE) && start;
  assign issue  = (state == S_RUN) && (ii_cnt == 8'd0) && !stall;
  assign en     = issue;

  // Odometer carries: each level wraps only when every inner level wraps too.
  assign wrap3     = (ctrl_vars[3] == E3_LAST);
  assign wrap2     = wrap3 && (ctrl_vars[2] == E2_LAST);
  assign wrap1     = wrap2 && (ctrl_vars[1] == E1_LAST);
  assign last_iter = wrap1 && (ctrl_vars[0] == E0_LAST);

  always_comb begin
    idx_inc    = ctrl_vars;
    idx_inc[3] = wrap3 ? 16'd0 : ctrl_vars[3] + 16'd1;
    if (wrap3) begin
      idx_inc[2] = (ctrl_vars[2] == E2_LAST) ? 16'd0 : ctrl_vars[2] + 16'd1;
    end
    if (wrap2) begin
      idx_inc[1] = (ctrl_vars[1] == E1_LAST) ? 16'd0 : ctrl_vars[1] + 16'd1;
    end
    if (wrap1) begin
      idx_inc[0] = (ctrl_vars[0] == E0_LAST) ? 16'd0 : ctrl_vars[0] + 16'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (START_DELAY == 0) ? S_RUN : S_DELAY;
        end
      end
      S_DELAY: begin
        busy = 1'b1;
        if (delay_cnt == 16'd0) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (issue && last_iter) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state     <= S_IDLE;
      ii_cnt    <= 8'd0;
      delay_cnt <= 16'd0;
      ctrl_vars <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        // ii_cnt may still be counting down from the previous run's last issue.
        delay_cnt <= DELAY_LOAD;
        ii_cnt    <= 8'd0;
        ctrl_vars <= '0;
      end else begin
        if ((state == S_DELAY) && (delay_cnt != 16'd0)) begin
          delay_cnt <= delay_cnt - 16'd1;
        end
        if (issue) begin
          ii_cnt    <= II_LAST;
          ctrl_vars <= idx_inc;
        end else if (ii_cnt != 8'd0) begin
          ii_cnt <= ii_cnt - 8'd1;
        end
      end
    end
  end

`ifdef DS_LOOP_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || flush || accept) begin
      perf_cycles <= 32'd0;
      perf_stalls <= 32'd0;
    end else begin
      if (busy && (perf_cycles != 32'hFFFF_FFFF)) begin
        perf_cycles <= perf_cycles + 32'd1;
      end
      if ((state == S_RUN) && (ii_cnt == 8'd0) && stall && (perf_stalls != 32'hFFFF_FFFF)) begin
        perf_stalls <= perf_stalls + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_down_sample_affine_loop_ctrl.sv
// Self-checking bench for down_sample_affine_loop_ctrl.
// dut_a: default parameters (4096-iteration nest), hand-written sequences.
// dut_b: EXTENT 1,2,2,2, II=3, START_DELAY=5, table-driven vectors.
// dut_c: EXTENT 2,3,1,3, II=2, START_DELAY=2, random stimulus vs. a
//        timestamp-based reference model.
// dut_d: only with DS_LOOP_CTRL_PERF_EN, performance counter check.

module tb_down_sample_affine_loop_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic a_rst = 1'b1, a_flush = 1'b0, a_start = 1'b0, a_stall = 1'b0;
  logic b_rst = 1'b1, b_flush = 1'b0, b_start = 1'b0, b_stall = 1'b0;
  logic c_rst = 1'b1, c_flush = 1'b0, c_start = 1'b0, c_stall = 1'b0;
  logic a_en, a_busy, a_done;
  logic b_en, b_busy, b_done;
  logic c_en, c_busy, c_done;
  logic [3:0][15:0] a_cv, b_cv, c_cv;
`ifdef DS_LOOP_CTRL_PERF_EN
  logic [31:0] a_pc, a_ps, b_pc, b_ps, c_pc, c_ps, d_pc, d_ps;
  logic d_rst = 1'b1, d_flush = 1'b0, d_start = 1'b0, d_stall = 1'b0;
  logic d_en, d_busy, d_done;
  logic [3:0][15:0] d_cv;
`endif

  down_sample_affine_loop_ctrl dut_a (
    .clk(clk), .rst(a_rst), .flush(a_flush), .start(a_start), .stall(a_stall),
    .en(a_en), .ctrl_vars(a_cv), .busy(a_busy), .done(a_done)
`ifdef DS_LOOP_CTRL_PERF_EN
    , .perf_cycles(a_pc), .perf_stalls(a_ps)
`endif
  );

  down_sample_affine_loop_ctrl #(
    .EXTENT0(1), .EXTENT1(2), .EXTENT2(2), .EXTENT3(2), .II(3), .START_DELAY(5)
  ) dut_b (
    .clk(clk), .rst(b_rst), .flush(b_flush), .start(b_start), .stall(b_stall),
    .en(b_en), .ctrl_vars(b_cv), .busy(b_busy), .done(b_done)
`ifdef DS_LOOP_CTRL_PERF_EN
    , .perf_cycles(b_pc), .perf_stalls(b_ps)
`endif
  );

  down_sample_affine_loop_ctrl #(
    .EXTENT0(2), .EXTENT1(3), .EXTENT2(1), .EXTENT3(3), .II(2), .START_DELAY(2)
  ) dut_c (
    .clk(clk), .rst(c_rst), .flush(c_flush), .start(c_start), .stall(c_stall),
    .en(c_en), .ctrl_vars(c_cv), .busy(c_busy), .done(c_done)
`ifdef DS_LOOP_CTRL_PERF_EN
    , .perf_cycles(c_pc), .perf_stalls(c_ps)
`endif
  );

`ifdef DS_LOOP_CTRL_PERF_EN
  down_sample_affine_loop_ctrl #(
    .EXTENT0(1), .EXTENT1(1), .EXTENT2(1), .EXTENT3(4), .II(2), .START_DELAY(0)
  ) dut_d (
    .clk(clk), .rst(d_rst), .flush(d_flush), .start(d_start), .stall(d_stall),
    .en(d_en), .ctrl_vars(d_cv), .busy(d_busy), .done(d_done),
    .perf_cycles(d_pc), .perf_stalls(d_ps)
  );
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Index vector of the n-th iteration (0-based) by plain division.
  function automatic logic [63:0] cv_of(input int n, input int e0, input int e1,
                                        input int e2, input int e3);
    logic [3:0][15:0] v;
    v[3] = 16'(n % e3);
    v[2] = 16'((n / e3) % e2);
    v[1] = 16'((n / (e3 * e2)) % e1);
    v[0] = 16'((n / (e3 * e2 * e1)) % e0);
    return v;
  endfunction

  function automatic logic [63:0] cv_lit(input int i0, input int i1, input int i2, input int i3);
    logic [3:0][15:0] v;
    v[0] = 16'(i0);
    v[1] = 16'(i1);
    v[2] = 16'(i2);
    v[3] = 16'(i3);
    return v;
  endfunction

  typedef struct {
    logic        start;
    logic        stall;
    logic        en;
    logic        busy;
    logic        done;
    logic [63:0] cv;
  } vec_t;

  initial begin
    vec_t tbl[32];
    int   n, first, last, dcyc, dcnt, busy_cnt, sl, stalled, i40, i41, fl, seen;
    int   m_active, m_accept, m_last, m_n, m_done;
    logic in_run, e_en;

    // dut_b expectations: delay occupies cycles 1..5, issues at 6,9,..,27, done at 28.
    // Extra stalls in DELAY and between issues must not move anything;
    // a start during the DONE cycle must be ignored.
    for (int c = 0; c < 32; c++) begin
      tbl[c].start = (c == 0) || (c == 28);
      tbl[c].stall = (c == 3) || (c == 7) || (c == 14);
      tbl[c].en    = (c >= 6) && (c <= 27) && ((c - 6) % 3 == 0);
      tbl[c].busy  = (c >= 1) && (c <= 27);
      tbl[c].done  = (c == 28);
      tbl[c].cv    = tbl[c].en ? cv_of((c - 6) / 3, 1, 2, 2, 2) : 64'd0;
    end

    // reset
    @(negedge clk);
    @(negedge clk); #1;
    chk("reset_en", a_en, 1'b0);
    chk("reset_busy", a_busy, 1'b0);
    chk("reset_done", a_done, 1'b0);
    chk("reset_cv", a_cv, 64'd0);
    @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
`ifdef DS_LOOP_CTRL_PERF_EN
    d_rst = 1'b0;
`endif

    // rst together with start in IDLE
    @(negedge clk); a_rst = 1'b1; a_start = 1'b1; #1;
    @(negedge clk); a_rst = 1'b0; a_start = 1'b0; #1;
    chk("rst_start_en", a_en, 1'b0);
    chk("rst_start_busy", a_busy, 1'b0);
    chk("rst_start_done", a_done, 1'b0);
    chk("rst_start_cv", a_cv, 64'd0);
    @(negedge clk); #1;
    chk("rst_start_still_idle", a_busy, 1'b0);

    // full default run, no stall
    n = 0; first = -1; last = -1; dcyc = -1; dcnt = 0; busy_cnt = 0;
    for (int cyc = 0; cyc < 4200; cyc++) begin
      @(negedge clk); a_start = (cyc == 0); #1;
      if (a_en) begin
        if (n == 0) first = cyc;
        if (n == 32) chk("a_issue33_cv", a_cv, cv_lit(0, 0, 1, 0));
        if (n == 4095) chk("a_last_cv", a_cv, cv_lit(0, 3, 31, 31));
        chk("a_run_cv", a_cv, cv_of(n, 1, 4, 32, 32));
        last = cyc;
        n++;
      end
      if (a_busy) busy_cnt++;
      if (a_done) begin dcnt++; dcyc = cyc; end
    end
    chk("a_issue_count", n, 4096);
    chk("a_first_en_cycle", first, 1);
    chk("a_last_en_cycle", last, 4096);
    chk("a_done_after_last", dcyc, last + 1);
    chk("a_done_pulses", dcnt, 1);
    chk("a_busy_cycles", busy_cnt, 4096);

    // stall for 10 cycles after issue 40
    n = 0; sl = 0; stalled = 0; i40 = -1; i41 = -1; dcnt = 0;
    for (int cyc = 0; cyc < 4300; cyc++) begin
      @(negedge clk);
      a_start = (cyc == 0);
      if (n == 40 && stalled == 0) begin sl = 10; stalled = 1; end
      a_stall = (sl > 0);
      if (sl > 0) sl--;
      #1;
      if (a_stall) chk("a_stall_en", a_en, 1'b0);
      if (a_en) begin
        if (n == 39) i40 = cyc;
        if (n == 40) begin
          i41 = cyc;
          chk("a_issue41_cv", a_cv, cv_lit(0, 0, 1, 8));
        end
        n++;
      end
      if (a_done) dcnt++;
    end
    a_stall = 1'b0;
    chk("a_stall_issue_count", n, 4096);
    chk("a_stall_gap", i41 - i40, 11);
    chk("a_stall_done_pulses", dcnt, 1);

    // flush during issue 100
    n = 0; fl = 0;
    for (int cyc = 0; cyc < 300 && fl == 0; cyc++) begin
      @(negedge clk); a_start = (cyc == 0); a_flush = (n == 99); #1;
      if (a_flush) begin
        chk("a_flush_cycle_en", a_en, 1'b1);
        chk("a_flush_cycle_cv", a_cv, cv_of(99, 1, 4, 32, 32));
        fl = 1;
      end
      if (a_en) n++;
    end
    chk("a_flush_reached", fl, 1);
    @(negedge clk); a_flush = 1'b0; #1;
    chk("a_flush_en", a_en, 1'b0);
    chk("a_flush_busy", a_busy, 1'b0);
    chk("a_flush_cv", a_cv, 64'd0);
    chk("a_flush_done", a_done, 1'b0);
    seen = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk); #1;
      if (a_done || a_busy || a_en) seen++;
    end
    chk("a_flush_quiet", seen, 0);
    @(negedge clk); a_start = 1'b1; #1;
    @(negedge clk); a_start = 1'b0; #1;
    chk("a_restart_en", a_en, 1'b1);
    chk("a_restart_cv0", a_cv, cv_lit(0, 0, 0, 0));
    @(negedge clk); #1;
    chk("a_restart_cv1", a_cv, cv_lit(0, 0, 0, 1));
    @(negedge clk); a_rst = 1'b1;
    @(negedge clk); a_rst = 1'b0;

    // table-driven vectors on dut_b
    for (int c = 0; c < 32; c++) begin
      @(negedge clk); b_start = tbl[c].start; b_stall = tbl[c].stall; #1;
      chk($sformatf("b_en_c%0d", c), b_en, tbl[c].en);
      chk($sformatf("b_busy_c%0d", c), b_busy, tbl[c].busy);
      chk($sformatf("b_done_c%0d", c), b_done, tbl[c].done);
      if (tbl[c].en) chk($sformatf("b_cv_c%0d", c), b_cv, tbl[c].cv);
    end
    b_start = 1'b0; b_stall = 1'b0;

    // random stimulus on dut_c against a timestamp model
    m_active = 0; m_accept = 0; m_last = 0; m_n = 0; m_done = -10;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      c_rst   = ($urandom_range(0, 299) == 0);
      c_flush = ($urandom_range(0, 149) == 0);
      c_start = ($urandom_range(0, 3) == 0);
      c_stall = ($urandom_range(0, 9) < 3);
      #1;
      in_run = (m_active != 0) && (cyc >= m_accept + 1 + 2);
      e_en   = in_run && (cyc - m_last >= 2) && !c_stall;
      chk("c_en", c_en, e_en);
      chk("c_busy", c_busy, m_active != 0);
      chk("c_done", c_done, cyc == m_done);
      if (e_en) chk("c_cv", c_cv, cv_of(m_n, 2, 3, 1, 3));
      if (c_rst || c_flush) begin
        m_active = 0;
        m_done   = -10;
      end else if (e_en) begin
        m_last = cyc;
        m_n++;
        if (m_n == 18) begin
          m_active = 0;
          m_done   = cyc + 1;
        end
      end else if (m_active == 0 && cyc != m_done && c_start) begin
        m_active = 1;
        m_accept = cyc;
        m_last   = cyc - 100;
        m_n      = 0;
      end
    end
    c_rst = 1'b0; c_flush = 1'b0; c_start = 1'b0; c_stall = 1'b0;

`ifdef DS_LOOP_CTRL_PERF_EN
    // issues at 1,6,8,10 with stalls at 3..5 while ii_cnt is 0
    dcnt = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk); d_start = (cyc == 0); d_stall = (cyc >= 3 && cyc <= 5); #1;
      if (d_done) dcnt++;
    end
    d_stall = 1'b0;
    chk("d_done_pulses", dcnt, 1);
    chk("d_perf_stalls", d_ps, 32'd3);
    chk("d_perf_cycles", d_pc, 32'd10);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
